// File: rtl/int_irq_ctrl.sv
// int_irq_ctrl: masks latched interrupt status with a CPU-writable enable
// register, optionally holds off (coalesces) a new event for hold_i cycles,
// then raises a single irq with the index of the lowest pending source and
// runs an assert/acknowledge/clear handshake before re-arming.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   cpuren_i  CPU read enable for the enable mask
//   cpuwen_i  CPU write enable for the enable mask
//   cpudi_i   CPU write data (enable mask)
//   cpudo_o   CPU read data (enable mask), combinational
//   hold_i    hold-off cycle count, quasi-static
//   sts_i     latched interrupt status
//   irq_o     interrupt request, registered
//   irq_id_o  index of the signalled source, registered
//   ack_i     single-cycle acknowledge of irq_o
module int_irq_ctrl #(
    parameter int unsigned    DW         = 8,
    parameter int unsigned    IDW        = 3,
    parameter int unsigned    HOLD_W     = 4,
    parameter logic [DW-1:0]  EN_RST_VAL = {DW{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpuren_i,
    input  logic              cpuwen_i,
    input  logic [DW-1:0]     cpudi_i,
    output logic [DW-1:0]     cpudo_o,
    input  logic [HOLD_W-1:0] hold_i,
    input  logic [DW-1:0]     sts_i,
    output logic              irq_o,
    output logic [IDW-1:0]    irq_id_o,
    input  logic              ack_i
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_HOLD     = 2'd1;
    localparam logic [1:0] ST_ASSERT   = 2'd2;
    localparam logic [1:0] ST_WAIT_CLR = 2'd3;

    logic [DW-1:0]     en_reg;
    logic [DW-1:0]     pend;
    logic [IDW-1:0]    sel;
    logic              id_pend;
    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [HOLD_W-1:0] cnt;
    logic [HOLD_W-1:0] cnt_nx;
    logic [IDW-1:0]    irq_id_nx;

    // Enable mask register; a write only affects pend from the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_reg <= EN_RST_VAL;
        end else if (cpuwen_i) begin
            en_reg <= cpudi_i;
        end
    end

    assign cpudo_o = cpuren_i ? en_reg : '0;
    assign pend    = sts_i & en_reg;
    assign id_pend = pend[irq_id_o];

    // Lowest set bit wins: scan from the top so the last hit is the lowest.
    always_comb begin
        sel = '0;
        for (int i = int'(DW) - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel = IDW'(i);
            end
        end
    end

    // Next-state logic for the handshake FSM.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        irq_id_nx = irq_id_o;
        case (state)
            ST_IDLE: begin
                if (pend != '0) begin
                    if (hold_i == '0) begin
                        state_nx  = ST_ASSERT;
                        irq_id_nx = sel;
                    end else begin
                        state_nx = ST_HOLD;
                        cnt_nx   = hold_i;
                    end
                end
            end
            ST_HOLD: begin
                if (pend == '0) begin
                    state_nx = ST_IDLE;
                end else if (cnt == HOLD_W'(1)) begin
                    state_nx  = ST_ASSERT;
                    irq_id_nx = sel;
                end else begin
                    cnt_nx = cnt - HOLD_W'(1);
                end
            end
            ST_ASSERT: begin
                // Acknowledge wins over a simultaneous withdrawal.
                if (ack_i) begin
                    state_nx = ST_WAIT_CLR;
                end else if (!id_pend) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_WAIT_CLR: begin
                if (!id_pend) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered irq outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            irq_o    <= 1'b0;
            irq_id_o <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            irq_o    <= (state_nx == ST_ASSERT);
            irq_id_o <= irq_id_nx;
        end
    end

endmodule
